bf_stream_loader: RTL and testbench

Host-side staging block for the 16-lane Bellman-Ford processing block. It deserializes a 32-bit word stream into 512-bit rows and writes them into the shared banked distance/weight memory. It then pulses the processing block's start, waits for its finish, reads every row back and serializes the results onto a 32-bit output stream. It sits directly upstream of the processing block (memory fill and launch) and directly downstream of it (result drain).

---
 rtl/bf_stream_loader_if.sv | 32 +++
 rtl/bf_stream_loader.sv | 131 +++++++++++++
 tb/tb_bf_stream_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/bf_stream_loader_if.sv
// Host stream and banked-memory bundle for bf_stream_loader.
// The master side is the loader, the slave side is the host/memory.
interface bf_stream_loader_if #(
    parameter int LANES  = 16,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         in_data;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_waddr;
    logic [LANES*DATA_W-1:0]   mem_wdata;
    logic                      mem_re;
    logic [ADDR_W-1:0]         mem_raddr;
    logic [LANES*DATA_W-1:0]   mem_rdata;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_data;

    modport master (
        input  in_valid, in_data, mem_rdata, out_ready,
        output in_ready, mem_we, mem_waddr, mem_wdata,
        output mem_re, mem_raddr, out_valid, out_data
    );

    modport slave (
        output in_valid, in_data, mem_rdata, out_ready,
        input  in_ready, mem_we, mem_waddr, mem_wdata,
        input  mem_re, mem_raddr, out_valid, out_data
    );
endinterface

// File: rtl/bf_stream_loader.sv
// Stages host words into 512-bit memory rows, launches the Bellman-Ford
// block, then drains the result rows back out as a 32-bit stream.
module bf_stream_loader #(
    parameter int LANES  = 16,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_global,
    input  logic              go,
    input  logic [ADDR_W-1:0] cfg_last_row,
    output logic              busy,
    output logic              done,
    output logic              pb_start,
    input  logic              pb_finish,
    bf_stream_loader_if.master bus
);
    localparam int LW    = $clog2(LANES);
    localparam int ROW_W = LANES * DATA_W;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_KICK,
        S_WAIT,
        S_READ,
        S_CAPTURE,
        S_SER,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [ADDR_W-1:0] last_row;
    logic [ADDR_W-1:0] row_cnt;
    logic [LW-1:0]     lane_cnt;
    logic [ROW_W-1:0]  row_buf;
    logic [ROW_W-1:0]  shreg;
    logic              fin_q;

    logic in_acc;
    logic out_acc;
    logic row_last;
    logic lane_last;

    assign in_acc    = (state == S_LOAD) && bus.in_valid;
    assign out_acc   = (state == S_SER) && bus.out_ready;
    assign row_last  = (row_cnt == last_row);
    assign lane_last = (lane_cnt == LW'(LANES - 1));

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:    if (go) state_d = S_LOAD;
            S_LOAD:    if (in_acc && lane_last) state_d = S_WRITE;
            S_WRITE:   state_d = row_last ? S_KICK : S_LOAD;
            S_KICK:    state_d = S_WAIT;
            // only a fresh rising edge counts; a stale high level is ignored
            S_WAIT:    if (pb_finish && !fin_q) state_d = S_READ;
            S_READ:    state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_SER;
            S_SER: begin
                if (out_acc && lane_last)
                    state_d = row_last ? S_DONE : S_READ;
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_global) begin
        if (!rst_global) state <= S_IDLE;
        else             state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_global) begin
        if (!rst_global) begin
            last_row <= '0;
            row_cnt  <= '0;
            lane_cnt <= '0;
            row_buf  <= '0;
            shreg    <= '0;
            fin_q    <= 1'b0;
        end else begin
            fin_q <= pb_finish;
            unique case (state)
                S_IDLE: begin
                    row_cnt  <= '0;
                    lane_cnt <= '0;
                    if (go) last_row <= cfg_last_row;
                end
                S_LOAD: begin
                    if (in_acc) begin
                        row_buf[lane_cnt*DATA_W +: DATA_W] <= bus.in_data;
                        lane_cnt <= lane_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    lane_cnt <= '0;
                    row_cnt  <= row_last ? '0 : row_cnt + 1'b1;
                end
                S_CAPTURE: begin
                    shreg    <= bus.mem_rdata;
                    lane_cnt <= '0;
                end
                S_SER: begin
                    if (out_acc) begin
                        shreg    <= shreg >> DATA_W;
                        lane_cnt <= lane_cnt + 1'b1;
                        if (lane_last && !row_last)
                            row_cnt <= row_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign pb_start      = (state == S_KICK);
    assign bus.in_ready  = (state == S_LOAD);
    assign bus.mem_we    = (state == S_WRITE);
    assign bus.mem_waddr = row_cnt;
    assign bus.mem_wdata = row_buf;
    assign bus.mem_re    = (state == S_READ);
    assign bus.mem_raddr = row_cnt;
    assign bus.out_valid = (state == S_SER);
    assign bus.out_data  = shreg[DATA_W-1:0];
endmodule

// File: tb/tb_bf_stream_loader.sv
// Randomized bench for bf_stream_loader with a word-queue reference model
// and a memory model whose processing block adds 0x100 to every lane.
module tb_bf_stream_loader;
    localparam int LANES = 16;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int RW    = LANES * DW;

    logic          clk = 1'b0;
    logic          rst_global = 1'b0;
    logic          go = 1'b0;
    logic [AW-1:0] cfg_last_row = '0;
    logic          busy;
    logic          done;
    logic          pb_start;
    logic          pb_finish = 1'b0;

    int n_pass = 0;
    int n_chk  = 0;

    bf_stream_loader_if #(.LANES(LANES), .DATA_W(DW), .ADDR_W(AW)) bus ();

    bf_stream_loader #(.LANES(LANES), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_global   (rst_global),
        .go           (go),
        .cfg_last_row (cfg_last_row),
        .busy         (busy),
        .done         (done),
        .pb_start     (pb_start),
        .pb_finish    (pb_finish),
        .bus          (bus.master)
    );

    always #5 clk = ~clk;

    logic [RW-1:0] mem [0:1023];

    function automatic logic [RW-1:0] pb_xform(input logic [RW-1:0] r);
        logic [RW-1:0] o;
        o = r;
        for (int k = 0; k < LANES; k++)
            o[k*DW +: DW] = r[k*DW +: DW] + 32'h100;
        return o;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= pb_xform(mem[bus.mem_raddr]);
    end

    task automatic check(input string tag, input logic [RW-1:0] got,
                         input logic [RW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [RW-1:0] row_of(input logic [DW-1:0] w[$],
                                             input int row);
        logic [RW-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++)
            r[k*DW +: DW] = w[row*LANES + k];
        return r;
    endfunction

    task automatic check_rst_outs(input string pfx);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_pb_start"}, pb_start, 0);
        check({pfx, "_in_ready"}, bus.in_ready, 0);
        check({pfx, "_mem_we"}, bus.mem_we, 0);
        check({pfx, "_mem_re"}, bus.mem_re, 0);
        check({pfx, "_out_valid"}, bus.out_valid, 0);
        check({pfx, "_waddr"}, bus.mem_waddr, 0);
        check({pfx, "_wdata"}, bus.mem_wdata, 0);
        check({pfx, "_raddr"}, bus.mem_raddr, 0);
        check({pfx, "_out_data"}, bus.out_data, 0);
    endtask

    task automatic run_job(input int last, input bit seq, input bit gap,
                           input bit fin_pre, input int stall_at,
                           input bit rnd_ready);
        int n;
        int idx;
        int wr;
        int cyc;
        int oi;
        int rd;
        int stall;
        int re_early;
        bit tog;
        bit started;
        bit prev_we;
        bit got_done;
        bit busy_ok;
        logic [DW-1:0] w[$];
        logic [DW-1:0] q[$];

        n = (last + 1) * LANES;
        for (int i = 0; i < n; i++) begin
            w.push_back(seq ? DW'(i) : DW'($urandom));
            q.push_back(w[i] + 32'h100);
        end
        busy_ok = 1'b1;
        pb_finish = fin_pre;
        bus.out_ready = 1'b0;

        @(negedge clk);
        go = 1'b1;
        cfg_last_row = AW'(last);
        @(negedge clk);
        go = 1'b0;
        cfg_last_row = AW'($urandom);
        check("go_busy", busy, 1);
        check("go_in_ready", bus.in_ready, 1);

        idx = 0; wr = 0; cyc = 0; tog = 0; started = 0; prev_we = 0;
        while (!started && cyc < n * 3 + 100) begin
            if (!busy) busy_ok = 1'b0;
            if (bus.mem_we) begin
                check("waddr", bus.mem_waddr, wr);
                check("wdata", bus.mem_wdata, row_of(w, wr));
                check("in_ready_in_write", bus.in_ready, 0);
                wr++;
            end
            if (pb_start) begin
                check("start_after_last_write", prev_we, 1);
                check("rows_written", wr, last + 1);
                started = 1'b1;
            end
            prev_we = bus.mem_we;
            tog = ~tog;
            bus.in_valid = (idx < n) && (!gap || tog);
            bus.in_data = (idx < n) ? w[idx] : DW'($urandom);
            if (bus.in_valid && bus.in_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        if (!started) check("start_timeout", 0, 1);

        re_early = 0;
        if (fin_pre) begin
            repeat (6) begin
                if (bus.mem_re) re_early++;
                @(negedge clk);
            end
            pb_finish = 1'b0;
            repeat (3) begin
                if (bus.mem_re) re_early++;
                @(negedge clk);
            end
        end else begin
            repeat (4) begin
                if (bus.mem_re) re_early++;
                @(negedge clk);
            end
        end
        check("no_early_read", re_early, 0);
        pb_finish = 1'b1;

        oi = 0; rd = 0; stall = 0; cyc = 0; got_done = 0;
        while (!got_done && cyc < n * 5 + 200) begin
            if (!busy) busy_ok = 1'b0;
            if (bus.mem_re) begin
                check("raddr", bus.mem_raddr, rd);
                rd++;
            end
            if (done) begin
                check("words_at_done", oi, n);
                got_done = 1'b1;
            end
            if (bus.out_valid && oi == stall_at && stall < 5) begin
                bus.out_ready = 1'b0;
                check("stall_hold", bus.out_data, q[oi]);
                stall++;
            end else begin
                bus.out_ready = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (oi < n) check("out_data", bus.out_data, q[oi]);
                else check("extra_word", oi, n - 1);
                oi++;
            end
            @(negedge clk);
            cyc++;
        end
        if (!got_done) check("done_timeout", 0, 1);
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        check("busy_throughout", busy_ok, 1);
        if (stall_at >= 0) check("stall_cycles", stall, 5);
        pb_finish = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_rst_outs("reset");
        rst_global = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        run_job(0, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        run_job(3, 1'b0, 1'b1, 1'b0, -1, 1'b0);
        run_job(1, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        run_job(0, 1'b0, 1'b0, 1'b0, 7, 1'b0);
        run_job(2, 1'b0, 1'b1, 1'b0, -1, 1'b1);

        @(negedge clk);
        go = 1'b1;
        cfg_last_row = AW'(2);
        @(negedge clk);
        go = 1'b0;
        repeat (7) begin
            bus.in_valid = 1'b1;
            bus.in_data = DW'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("pre_reset_in_ready", bus.in_ready, 1);
        #2 rst_global = 1'b0;
        #1 check_rst_outs("async_reset");
        @(negedge clk);
        rst_global = 1'b1;
        run_job(1, 1'b0, 1'b0, 1'b0, -1, 1'b0);

        run_job(1023, 1'b0, 1'b0, 1'b0, 700, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
